// File: rtl/dw_fifo_32i_64o_8k.sv
// dw_fifo_32i_64o_8k: single-clock width-converting FIFO, 32-bit write side, 64-bit read side, 8192 write words deep.
//   clk            : clock for both ports
//   tb_rst         : asynchronous active-high reset, empties the FIFO
//   wr_data/wr_en  : 32-bit write word and request (ignored while wr_full)
//   wr_full        : 8192 write words stored
//   wr_water_level : occupancy in write words (0..8192)
//   almost_full    : wr_water_level >= ALMOST_FULL_NUM
//   rd_data/rd_en  : 64-bit read word (registered, valid the cycle after an accepted read) and request
//   rd_empty       : fewer than two write words stored
//   rd_water_level : occupancy in read words (0..4096)
//   almost_empty   : rd_water_level <= ALMOST_EMPTY_NUM
//   Macro FIFO_ALMOST_FLAGS_EN enables almost_full/almost_empty; when undefined both are tied low.
module dw_fifo_32i_64o_8k #(
  parameter int WR_DEPTH_WIDTH   = 13,
  parameter int WR_DATA_WIDTH    = 32,
  parameter int RD_DEPTH_WIDTH   = 12,
  parameter int RD_DATA_WIDTH    = 64,
  parameter int ALMOST_FULL_NUM  = 252,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                      clk,
  input  logic                      tb_rst,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  input  logic                      rd_en,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty
);
  localparam logic [WR_DEPTH_WIDTH:0] FULL_LVL = {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
  // Storage split into a low and a high 32-bit bank; write-pointer bit 0 picks the bank,
  // so the first word of a pair lands in rd_data[31:0] and the second in rd_data[63:32].
  logic [WR_DATA_WIDTH-1:0] mem_lo [0:(1<<RD_DEPTH_WIDTH)-1];
  logic [WR_DATA_WIDTH-1:0] mem_hi [0:(1<<RD_DEPTH_WIDTH)-1];
  logic [WR_DEPTH_WIDTH:0]  wr_ptr_q, wr_ptr_d;
  logic [RD_DEPTH_WIDTH:0]  rd_ptr_q, rd_ptr_d;
  logic [WR_DEPTH_WIDTH:0]  level_q, level_d;
  logic                     full_q, full_d;
  logic                     empty_q, empty_d;
  logic [RD_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                     wr_acc, rd_acc;
  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;
  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{WR_DEPTH_WIDTH{1'b0}}, wr_acc};
    rd_ptr_d  = rd_ptr_q + {{RD_DEPTH_WIDTH{1'b0}}, rd_acc};
    // Read pointer counts 64-bit words; doubling it puts both pointers in write-word units.
    level_d   = wr_ptr_d - {rd_ptr_d, 1'b0};
    full_d    = level_d == FULL_LVL;
    empty_d   = ~|level_d[WR_DEPTH_WIDTH:1];
    rd_data_d = rd_acc ? {mem_hi[rd_ptr_q[RD_DEPTH_WIDTH-1:0]], mem_lo[rd_ptr_q[RD_DEPTH_WIDTH-1:0]]} : rd_data_q;
  end
  always_ff @(posedge clk) begin
    if (wr_acc && wr_ptr_q[0]) mem_hi[wr_ptr_q[WR_DEPTH_WIDTH-1:1]] <= wr_data;
    if (wr_acc && !wr_ptr_q[0]) mem_lo[wr_ptr_q[WR_DEPTH_WIDTH-1:1]] <= wr_data;
  end
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign wr_full        = full_q;
  assign rd_empty       = empty_q;
  assign wr_water_level = level_q;
  assign rd_water_level = level_q[WR_DEPTH_WIDTH:1];
  assign rd_data        = rd_data_q;
`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [WR_DEPTH_WIDTH:0] AF_LVL = ALMOST_FULL_NUM[WR_DEPTH_WIDTH:0];
  localparam logic [RD_DEPTH_WIDTH:0] AE_LVL = ALMOST_EMPTY_NUM[RD_DEPTH_WIDTH:0];
  assign almost_full  = level_q >= AF_LVL;
  assign almost_empty = rd_water_level <= AE_LVL;
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif
endmodule

// File: tb/tb_dw_fifo_32i_64o_8k.sv
// tb_dw_fifo_32i_64o_8k: randomized scoreboard bench for the 32-in/64-out FIFO against a queue model.
`timescale 1ns/1ps
module tb_dw_fifo_32i_64o_8k;
  logic        clk = 1'b0;
  logic        tb_rst = 1'b1;
  logic [31:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_full, almost_full, rd_empty, almost_empty;
  logic [13:0] wr_water_level;
  logic [12:0] rd_water_level;
  logic [63:0] rd_data;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] last_rd = '0;
  dw_fifo_32i_64o_8k dut (
    .clk(clk), .tb_rst(tb_rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
    .wr_water_level(wr_water_level), .almost_full(almost_full), .rd_data(rd_data),
    .rd_en(rd_en), .rd_empty(rd_empty), .rd_water_level(rd_water_level), .almost_empty(almost_empty)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_state();
    int s;
    bit af, ae;
    s = m_q.size();
`ifdef FIFO_ALMOST_FLAGS_EN
    af = s >= 252;
    ae = (s / 2) <= 4;
`else
    af = 1'b0;
    ae = 1'b0;
`endif
    chk("wr_water_level", 64'(wr_water_level), 64'(s));
    chk("rd_water_level", 64'(rd_water_level), 64'(s / 2));
    chk("wr_full", 64'(wr_full), 64'(s == 8192));
    chk("rd_empty", 64'(rd_empty), 64'(s < 2));
    chk("almost_full", 64'(almost_full), 64'(af));
    chk("almost_empty", 64'(almost_empty), 64'(ae));
    chk("rd_data_hold", rd_data, last_rd);
  endtask
  task automatic cyc(input bit we, input logic [31:0] wd, input bit re);
    bit ra, wa;
    logic [31:0] a, b;
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    @(posedge clk);
    ra = re && m_q.size() >= 2;
    wa = we && m_q.size() < 8192;
    if (ra) begin
      a = m_q.pop_front();
      b = m_q.pop_front();
      last_rd = {b, a};
      exp_q.push_back(last_rd);
    end
    if (wa) m_q.push_back(wd);
    #1 chk_state();
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    tb_rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #200;
    m_q.delete();
    exp_q.delete();
    last_rd = '0;
    chk_state();
    tb_rst = 1'b0;
  endtask
  always begin
    @(posedge clk);
    if (!tb_rst && rd_en && !rd_empty) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got %h expected no read word", rd_data);
      end else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int wp[4] = '{90, 60, 30, 50};
    int rp[4] = '{30, 60, 90, 50};
    logic [31:0] a, b;
    do_reset();
    for (int i = 0; i < 8193; i++) cyc(1'b1, 32'hFFFF_FFFF - 32'(i), 1'b0);
    for (int i = 0; i < 4097; i++) cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0);
    do_reset();
    cyc(1'b1, 32'h1234_5678, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 32'h9ABC_DEF0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("odd_pair", rd_data, 64'h9ABC_DEF0_1234_5678);
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, 1'b0);
    cyc(1'b1, $urandom, 1'b1);
    chk("simul_level", 64'(wr_water_level), 64'd9);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 1500; i++)
        cyc($urandom_range(99) < wp[p], $urandom, $urandom_range(99) < rp[p]);
    for (int i = 0; i < 4096; i++) cyc(1'b1, $urandom, $urandom_range(99) < 10);
    do_reset();
    a = $urandom;
    b = $urandom;
    cyc(1'b1, a, 1'b0);
    cyc(1'b1, b, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("post_reset_pair", rd_data, {b, a});
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
